if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS32 pipeline. Owns the PC, issues word requests to a variable-latency instruction memory over a req/ready handshake, and loads the IF/ID pipeline register. It consumes the stall controls (`PCWrite`, `IFID_Write`) driven by the ID-stage hazard logic and the taken-branch redirect, and is the upstream producer of every instruction the ID-stage decoder sees.

---
 rtl/if_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC ownership, imem req/ready handshake,
// and the IF/ID pipeline register with stall and redirect handling.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IFID_Write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_PCplus4,
    output logic        IF_ID_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;

    logic        accept;
    logic [31:0] pc_plus4;

    assign accept   = PCWrite & IFID_Write;
    assign pc_plus4 = pc_q + 32'd4;

    // The request is withdrawn only while a fetched word sits in the buffer.
    assign imem_req  = reset & (state_q != HOLD);
    // An abandoned fetch keeps presenting its original address until it ends.
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    assign IF_ID_instr   = instr_q;
    assign IF_ID_PCplus4 = pc4_q;
    assign IF_ID_valid   = valid_q;

    // Next-state, next-PC and IF/ID load decisions; redirect wins over all.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        hold_d       = hold_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;

        if (branch_taken) begin
            pc_d    = branch_target & ~32'h3;
            hold_d  = 32'h0;
            instr_d = 32'h0;
            pc4_d   = 32'h0;
            valid_d = 1'b0;
            unique case (state_q)
                FETCH: begin
                    if (!imem_ready) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    state_d = imem_ready ? FETCH : DRAIN;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (imem_ready) begin
                        if (accept) begin
                            instr_d = imem_rdata;
                            pc4_d   = pc_plus4;
                            valid_d = 1'b1;
                            pc_d    = pc_plus4;
                        end else begin
                            hold_d  = imem_rdata;
                            state_d = HOLD;
                        end
                    end else if (IFID_Write) begin
                        instr_d = 32'h0;
                        pc4_d   = 32'h0;
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        instr_d = hold_q;
                        pc4_d   = pc_plus4;
                        valid_d = 1'b1;
                        pc_d    = pc_plus4;
                        state_d = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ready) begin
                        state_d = FETCH;
                    end
                    if (IFID_Write) begin
                        instr_d = 32'h0;
                        pc4_d   = 32'h0;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State, PC, buffers and IF/ID register with async active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            hold_q       <= 32'h0;
            drain_addr_q <= 32'h0;
            instr_q      <= 32'h0;
            pc4_q        <= 32'h0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            hold_q       <= hold_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed test-plan scenarios, then random
// stall/ready/redirect traffic against a queue-based reference model.
module tb_if_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        PCWrite = 1'b0;
    logic        IFID_Write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready = 1'b0;
    logic [31:0] IF_ID_instr;
    logic [31:0] IF_ID_PCplus4;
    logic        IF_ID_valid;

    int n_chk = 0;
    int n_pass = 0;

    if_fetch_unit #(.RESET_PC(32'h0000_0040)) dut (
        .clock(clock),
        .reset(reset),
        .PCWrite(PCWrite),
        .IFID_Write(IFID_Write),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .IF_ID_instr(IF_ID_instr),
        .IF_ID_PCplus4(IF_ID_PCplus4),
        .IF_ID_valid(IF_ID_valid)
    );

    always #5 clock = ~clock;

    // Memory contents: a fixed word at 0x40, otherwise a nonzero address hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h40) return 32'h2008_0005;
        return a ^ 32'hC0DE_0001;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    // Reference model: program counter, a buffered word (if any) and the
    // address of an abandoned in-flight request (if any).
    logic [31:0] m_pc;
    logic [31:0] held[$];
    logic [31:0] orphan[$];
    logic [31:0] m_instr, m_pc4;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic m_reset();
        m_pc = 32'h40;
        held.delete();
        orphan.delete();
        m_instr = 0;
        m_pc4 = 0;
        m_valid = 0;
    endtask

    function automatic logic m_req();
        return held.size() == 0;
    endfunction

    function automatic logic [31:0] m_addr();
        return (orphan.size() != 0) ? orphan[0] : m_pc;
    endfunction

    task automatic m_bubble();
        m_instr = 0;
        m_pc4 = 0;
        m_valid = 0;
    endtask

    task automatic m_step(input logic pw, input logic iw, input logic bt,
                          input logic [31:0] tgt, input logic rdy);
        logic busy_fetch;
        busy_fetch = (held.size() == 0) && (orphan.size() == 0);
        if (bt) begin
            m_bubble();
            held.delete();
            if (busy_fetch && !rdy) orphan.push_back(m_pc);
            else if (orphan.size() != 0 && rdy) orphan.delete();
            m_pc = {tgt[31:2], 2'b00};
        end else if (orphan.size() != 0) begin
            if (rdy) orphan.delete();
            if (iw) m_bubble();
        end else if (held.size() != 0) begin
            if (pw && iw) begin
                m_instr = held[0];
                m_pc4 = m_pc + 4;
                m_valid = 1;
                m_pc = m_pc + 4;
                held.delete();
            end
        end else if (rdy) begin
            if (pw && iw) begin
                m_instr = mem_word(m_pc);
                m_pc4 = m_pc + 4;
                m_valid = 1;
                m_pc = m_pc + 4;
            end else begin
                held.push_back(mem_word(m_pc));
            end
        end else if (iw) begin
            m_bubble();
        end
    endtask

    // One clock: called at a negedge, returns at the next negedge.
    task automatic step(input logic pw, input logic iw, input logic bt,
                        input logic [31:0] tgt, input logic rdy);
        PCWrite = pw;
        IFID_Write = iw;
        branch_taken = bt;
        branch_target = tgt;
        imem_ready = rdy;
        #1;
        chk("req", {31'b0, imem_req}, {31'b0, m_req()});
        chk("addr", imem_addr, m_addr());
        m_step(pw, iw, bt, tgt, rdy);
        @(posedge clock);
        #1;
        chk("instr", IF_ID_instr, m_instr);
        chk("pc4", IF_ID_PCplus4, m_pc4);
        chk("valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
        @(negedge clock);
    endtask

    initial begin
        m_reset();
        imem_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("rst_instr", IF_ID_instr, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Reset release, first fetch from RESET_PC
        step(1, 1, 0, 0, 1);
        chk("first_instr", IF_ID_instr, 32'h2008_0005);
        chk("first_pc4", IF_ID_PCplus4, 32'h44);
        chk("first_addr", imem_addr, 32'h44);
        step(1, 1, 0, 0, 1);

        // Stall while 0x48 completes
        step(0, 0, 0, 0, 1);
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_addr", imem_addr, 32'h48);
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        chk("hold_instr", IF_ID_instr, 32'h48 ^ 32'hC0DE_0001);
        chk("hold_next", imem_addr, 32'h4C);
        step(1, 1, 0, 0, 1);

        // Wait states at 0x50
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0, 0);
            chk("ws_valid", {31'b0, IF_ID_valid}, 32'h0);
            chk("ws_addr", imem_addr, 32'h50);
        end
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1);

        // Redirect with zero-wait memory at 0x60
        chk("br_at", imem_addr, 32'h60);
        step(1, 1, 1, 32'h100, 1);
        chk("br_bubble", {31'b0, IF_ID_valid}, 32'h0);
        chk("br_addr", imem_addr, 32'h100);
        step(1, 1, 0, 0, 1);
        chk("br_pc4", IF_ID_PCplus4, 32'h104);

        // Redirect during a pending fetch, then a second redirect in drain
        step(1, 1, 1, 32'h70, 1);
        step(1, 1, 1, 32'h200, 0);
        chk("drain_addr", imem_addr, 32'h70);
        step(1, 1, 1, 32'h300, 0);
        chk("drain_addr2", imem_addr, 32'h70);
        step(1, 1, 0, 0, 1);
        chk("drain_done", imem_addr, 32'h300);
        step(1, 1, 0, 0, 1);
        chk("drain_pc4", IF_ID_PCplus4, 32'h304);

        // PC wrap; target low bits are ignored
        step(1, 1, 1, 32'hFFFF_FFFE, 1);
        chk("wrap_at", imem_addr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 1);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_pc4", IF_ID_PCplus4, 32'h0);

        // Async reset asserted mid-HOLD
        step(0, 0, 0, 0, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("arst_addr", imem_addr, 32'h40);
        chk("arst_req", {31'b0, imem_req}, 32'h0);
        m_reset();
        @(negedge clock);
        reset = 1'b1;

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic pw, iw, bt, rdy;
            logic [31:0] tgt;
            pw  = ($urandom_range(0, 99) < 80);
            iw  = ($urandom_range(0, 99) < 85);
            bt  = ($urandom_range(0, 99) < 10);
            rdy = ($urandom_range(0, 99) < 60);
            tgt = $urandom;
            step(pw, iw, bt, tgt, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
